// File: rtl/gearbox_pkg.sv
// Shared definitions for the half-rate to full-rate gearbox and the /2 clock divider.
package gearbox_pkg;

    localparam int unsigned DIV_RATIO = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } gb_state_t;

endpackage

// File: rtl/gearbox_2to1_if.sv
// Wide-word in / narrow-beat out stream bundle for the gearbox.
interface gearbox_2to1_if
    import gearbox_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned RATIO = DIV_RATIO
);

    logic                 s_valid;
    logic                 s_ready;
    logic [RATIO*W-1:0]   s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [W-1:0]         m_data;
    logic                 m_first;
    logic                 m_last;

    // Environment view: produces wide words, consumes narrow beats.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_first, m_last
    );

    // Gearbox view.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_first, m_last
    );

endinterface

// File: rtl/gearbox_2to1.sv
// Splits each accepted wide word into RATIO narrow beats, LSB first, with a
// one-word staging buffer so the narrow side streams without bubbles.
module gearbox_2to1
    import gearbox_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned RATIO = DIV_RATIO
) (
    input  logic           clk,
    input  logic           rst,
    gearbox_2to1_if.slave  bus
);

    localparam int unsigned WORD_W = RATIO * W;
    localparam int unsigned CNT_W  = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if (RATIO < 2 || W < 1) begin : g_param_check
        $error("gearbox_2to1: RATIO must be >= 2 and W must be >= 1");
    end

    gb_state_t           state;
    gb_state_t           state_n;
    logic [WORD_W-1:0]   cur;
    logic [WORD_W-1:0]   cur_n;
    logic [WORD_W-1:0]   nxt;
    logic [WORD_W-1:0]   nxt_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [W-1:0]        beat_n;
    logic                take_s;
    logic                take_m;
    logic                retire;

    assign take_s = bus.s_valid && bus.s_ready;
    assign take_m = bus.m_valid && bus.m_ready;
    assign retire = take_m && (cnt == CNT_LAST);

    // State, buffers and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            cnt         <= '0;
            cur         <= '0;
            nxt         <= '0;
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_first <= 1'b1;
            bus.m_last  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur         <= cur_n;
            nxt         <= nxt_n;
            bus.s_ready <= (state_n != FULL);
            bus.m_valid <= (state_n != EMPTY);
            bus.m_data  <= beat_n;
            bus.m_first <= (cnt_n == '0);
            bus.m_last  <= (cnt_n == CNT_LAST);
        end
    end

    // Next-state, buffer movement and beat selection.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        nxt_n   = nxt;
        cnt_n   = cnt;

        if (take_m) begin
            cnt_n = retire ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            EMPTY: begin
                if (take_s) begin
                    cur_n   = bus.s_data;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (take_s && retire) begin
                    cur_n = bus.s_data;
                end else if (take_s) begin
                    nxt_n   = bus.s_data;
                    state_n = FULL;
                end else if (retire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so only the staged word can move up.
                if (retire) begin
                    cur_n   = nxt;
                    state_n = BUSY;
                end
            end
            default: begin
                state_n = EMPTY;
                cnt_n   = '0;
            end
        endcase

        beat_n = W'(cur_n >> (32'(cnt_n) * W));
    end

endmodule

// File: tb/tb_gearbox_2to1.sv
// Randomized and directed bench for gearbox_2to1 against a word/beat queue model.
module tb_gearbox_2to1;
    import gearbox_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned AR    = DIV_RATIO;
    localparam int unsigned AWORD = AW * AR;
    localparam int unsigned BW    = 4;
    localparam int unsigned BR    = 4;
    localparam int unsigned BWORD = BW * BR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gearbox_2to1_if #(.W(AW), .RATIO(AR)) a_if ();
    gearbox_2to1_if #(.W(BW), .RATIO(BR)) b_if ();

    gearbox_2to1 #(.W(AW), .RATIO(AR)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    gearbox_2to1 #(.W(BW), .RATIO(BR)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct {
        logic [AW-1:0] data;
        bit            first;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    int    held;
    bit    exp_ready;
    bit    last_acc;
    int    n_checks;
    int    n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: words held = accepted - retired; beats leave in LSB-first order.
    task automatic tick();
        bit            acc_s;
        bit            acc_m;
        logic [AWORD-1:0] w;
        beat_t         b;
        acc_s = 1'b0;
        acc_m = 1'b0;
        if (rst) begin
            check("rst_m_valid", 32'(a_if.m_valid), 32'(0));
            check("rst_s_ready", 32'(a_if.s_ready), 32'(0));
            check("rst_m_first", 32'(a_if.m_first), 32'(1));
        end else begin
            check("m_valid", 32'(a_if.m_valid), 32'(held > 0));
            check("s_ready", 32'(a_if.s_ready), 32'(exp_ready));
            if (a_if.m_valid && exp_q.size() > 0) begin
                check("m_data",  32'(a_if.m_data),  32'(exp_q[0].data));
                check("m_first", 32'(a_if.m_first), 32'(exp_q[0].first));
                check("m_last",  32'(a_if.m_last),  32'(exp_q[0].last));
            end
            acc_s = a_if.s_valid && a_if.s_ready;
            acc_m = a_if.m_valid && a_if.m_ready;
            if (acc_m && exp_q.size() > 0) begin
                if (exp_q[0].last) held--;
                void'(exp_q.pop_front());
            end
            if (acc_s) begin
                held++;
                w = a_if.s_data;
                for (int k = 0; k < int'(AR); k++) begin
                    b.data  = AW'(w >> (k * int'(AW)));
                    b.first = (k == 0);
                    b.last  = (k == int'(AR) - 1);
                    exp_q.push_back(b);
                end
            end
        end
        last_acc = acc_s;
        @(posedge clk);
        #1;
        exp_ready = !rst && (held != 2);
    endtask

    task automatic offer(input logic [AWORD-1:0] w);
        a_if.s_data  = w;
        a_if.s_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (last_acc) return;
        end
        check("offer_timeout", 32'(last_acc), 32'(1));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        exp_q.delete();
        held      = 0;
        exp_ready = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BWORD-1:0] bword;
        n_checks     = 0;
        n_errors     = 0;
        held         = 0;
        exp_ready    = 1'b0;
        last_acc     = 1'b0;
        a_if.s_valid = 1'b0;
        a_if.s_data  = '0;
        a_if.m_ready = 1'b1;
        b_if.s_valid = 1'b0;
        b_if.s_data  = '0;
        b_if.m_ready = 1'b1;

        @(posedge clk);
        #1;
        do_reset(3);
        tick();
        check("s_ready_after_rst", 32'(a_if.s_ready), 32'(1));

        // Single word.
        offer(16'hA55A);
        a_if.s_valid = 1'b0;
        check("single_b0", 32'(a_if.m_data), 32'h5A);
        check("single_first", 32'(a_if.m_first), 32'(1));
        tick();
        check("single_b1", 32'(a_if.m_data), 32'hA5);
        check("single_last", 32'(a_if.m_last), 32'(1));
        tick();
        check("single_done", 32'(a_if.m_valid), 32'(0));
        repeat (2) tick();

        // Streaming with s_valid held high.
        offer(16'h0201);
        offer(16'h0403);
        offer(16'h0605);
        a_if.s_valid = 1'b0;
        repeat (8) tick();

        // Backpressure while FULL.
        a_if.m_ready = 1'b0;
        offer(16'h2211);
        offer(16'h4433);
        a_if.s_valid = 1'b0;
        repeat (5) begin
            tick();
            check("bp_hold_data", 32'(a_if.m_data), 32'h11);
            check("bp_full", 32'(a_if.s_ready), 32'(0));
        end
        a_if.m_ready = 1'b1;
        repeat (6) tick();

        // Reset while FULL, then a fresh word.
        a_if.m_ready = 1'b0;
        offer(16'h7766);
        offer(16'h9988);
        a_if.s_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_full_m_valid", 32'(a_if.m_valid), 32'(0));
        do_reset(1);
        a_if.m_ready = 1'b1;
        offer(16'hBEEF);
        a_if.s_valid = 1'b0;
        check("beef_b0", 32'(a_if.m_data), 32'hEF);
        tick();
        check("beef_b1", 32'(a_if.m_data), 32'hBE);
        tick();
        check("beef_done", 32'(a_if.m_valid), 32'(0));

        // RATIO=4, W=4 instance.
        bword        = 16'h1234;
        b_if.s_data  = bword;
        b_if.s_valid = 1'b1;
        check("b_s_ready", 32'(b_if.s_ready), 32'(1));
        tick();
        b_if.s_valid = 1'b0;
        for (int k = 0; k < int'(BR); k++) begin
            check("b_m_valid", 32'(b_if.m_valid), 32'(1));
            check("b_m_data",  32'(b_if.m_data),  32'(BW'(bword >> (k * int'(BW)))));
            check("b_m_first", 32'(b_if.m_first), 32'(k == 0));
            check("b_m_last",  32'(b_if.m_last),  32'(k == int'(BR) - 1));
            tick();
        end
        check("b_done", 32'(b_if.m_valid), 32'(0));

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                a_if.s_valid = 1'b0;
                do_reset(1);
            end
            if (!a_if.s_valid || last_acc) begin
                a_if.s_valid = ($urandom_range(3) != 0);
                a_if.s_data  = AWORD'($urandom);
            end
            a_if.m_ready = ($urandom_range(3) != 0);
            tick();
        end
        a_if.s_valid = 1'b0;
        a_if.m_ready = 1'b1;
        repeat (10) tick();
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
